// File: rtl/rvfi_trace_pkg.sv
// Shared types and defaults for the RVFI trace generator.
// Optional feature macro: RVFI_TRACE_PC_CONT_EN (see rvfi_trace_gen.sv).
package rvfi_trace_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned DEPTH_DEF = 4;
    localparam int unsigned ORDER_W   = 8;
    localparam int unsigned MASK_W    = XLEN_DEF / 8;

    // One retirement event as held in the retire buffer.
    // pend: rd value arrives later on wb_*; done: entry is ready to emit.
    typedef struct packed {
        logic [31:0]         insn;
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] next_pc;
        logic                trap;
        logic [4:0]          rs1_addr;
        logic [XLEN_DEF-1:0] rs1_rdata;
        logic [4:0]          rs2_addr;
        logic [XLEN_DEF-1:0] rs2_rdata;
        logic [4:0]          rd;
        logic [XLEN_DEF-1:0] rd_wdata;
        logic [XLEN_DEF-1:0] mem_addr;
        logic [MASK_W-1:0]   mem_rmask;
        logic [MASK_W-1:0]   mem_wmask;
        logic [XLEN_DEF-1:0] mem_wdata;
        logic [XLEN_DEF-1:0] mem_rdata;
        logic                pend;
        logic                done;
    } ret_entry_t;

    // x0 writes and trapped instructions report no rd value.
    function automatic logic [XLEN_DEF-1:0] post_rd_value(input ret_entry_t e);
        return ((e.rd == 5'd0) || e.trap) ? '0 : e.rd_wdata;
    endfunction

endpackage

// File: rtl/rvfi_trace_fifo.sv
// Retire buffer: circular FIFO of ret_entry_t with extra-bit pointers,
// full/empty flags and the oldest-incomplete search used by late writebacks.
module rvfi_trace_fifo
    import rvfi_trace_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_push,
    input  ret_entry_t          i_push_entry,
    input  logic                i_pop,
    input  logic                i_wb_valid,
    input  logic [XLEN_DEF-1:0] i_wb_rd_wdata,
    input  logic [XLEN_DEF-1:0] i_wb_mem_rdata,
    output logic                o_full,
    output logic                o_empty,
    output ret_entry_t          o_head
);

    localparam int unsigned AW = $clog2(DEPTH);

    ret_entry_t  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;

    logic [AW:0]   w_count;
    logic          w_wb_hit;
    logic [AW-1:0] w_wb_idx;
    ret_entry_t    w_push_entry;

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (w_count == (AW+1)'(DEPTH));
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

    // Find the oldest buffered entry still waiting for its writeback.
    always_comb begin
        w_wb_hit = 1'b0;
        w_wb_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!w_wb_hit && ((AW+1)'(i) < w_count) &&
                !r_mem[r_rd_ptr[AW-1:0] + AW'(i)].done) begin
                w_wb_hit = 1'b1;
                w_wb_idx = r_rd_ptr[AW-1:0] + AW'(i);
            end
        end
    end

    // A writeback with nothing incomplete buffered completes a pending incoming entry.
    always_comb begin
        w_push_entry = i_push_entry;
        if (i_wb_valid && !w_wb_hit && i_push_entry.pend) begin
            w_push_entry.rd_wdata  = i_wb_rd_wdata;
            w_push_entry.mem_rdata = i_wb_mem_rdata;
            w_push_entry.done      = 1'b1;
        end
    end

    // Storage, pointer updates and writeback application.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= w_push_entry;
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (i_wb_valid && w_wb_hit) begin
                r_mem[w_wb_idx].rd_wdata  <= i_wb_rd_wdata;
                r_mem[w_wb_idx].mem_rdata <= i_wb_mem_rdata;
                r_mem[w_wb_idx].done      <= 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rvfi_trace_gen.sv
// Core-side RVFI producer (NRET=1): buffers retirement events until their rd
// value is known, then emits them in program order with a wrapping 8-bit order.
// Optional macro RVFI_TRACE_PC_CONT_EN adds the sticky pc_err continuity flag.
// XLEN must match the package XLEN_DEF, which sizes the buffered entry.
module rvfi_trace_gen
    import rvfi_trace_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ret_valid,
    output logic                 ret_ready,
    input  logic [31:0]          ret_insn,
    input  logic [XLEN-1:0]      ret_pc,
    input  logic [XLEN-1:0]      ret_next_pc,
    input  logic                 ret_trap,
    input  logic [4:0]           ret_rs1_addr,
    input  logic [XLEN-1:0]      ret_rs1_rdata,
    input  logic [4:0]           ret_rs2_addr,
    input  logic [XLEN-1:0]      ret_rs2_rdata,
    input  logic [4:0]           ret_rd,
    input  logic [XLEN-1:0]      ret_rd_wdata,
    input  logic                 ret_wb_pend,
    input  logic [XLEN-1:0]      ret_mem_addr,
    input  logic [XLEN/8-1:0]    ret_mem_rmask,
    input  logic [XLEN/8-1:0]    ret_mem_wmask,
    input  logic [XLEN-1:0]      ret_mem_wdata,
    input  logic                 wb_valid,
    input  logic [XLEN-1:0]      wb_rd_wdata,
    input  logic [XLEN-1:0]      wb_mem_rdata,
    output logic                 rvfi_valid,
    output logic [ORDER_W-1:0]   rvfi_order,
    output logic [31:0]          rvfi_insn,
    output logic [XLEN-1:0]      rvfi_pre_pc,
    output logic [XLEN-1:0]      rvfi_post_pc,
    output logic                 rvfi_trap,
    output logic [4:0]           rvfi_rs1_addr,
    output logic [XLEN-1:0]      rvfi_rs1_rdata,
    output logic [4:0]           rvfi_rs2_addr,
    output logic [XLEN-1:0]      rvfi_rs2_rdata,
    output logic [4:0]           rvfi_rd,
    output logic [XLEN-1:0]      rvfi_post_rd,
    output logic [XLEN-1:0]      rvfi_mem_addr,
    output logic [XLEN/8-1:0]    rvfi_mem_rmask,
    output logic [XLEN/8-1:0]    rvfi_mem_wmask,
    output logic [XLEN-1:0]      rvfi_mem_rdata,
`ifdef RVFI_TRACE_PC_CONT_EN
    output logic                 pc_err,
`endif
    output logic [XLEN-1:0]      rvfi_mem_wdata
);

    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_accept;
    logic               w_bypass;
    logic               w_push;
    logic               w_pop;
    logic               w_emit;
    ret_entry_t         w_in_entry;
    ret_entry_t         w_head;
    ret_entry_t         w_emit_entry;
    logic [ORDER_W-1:0] r_order_cnt;

    assign ret_ready = !w_fifo_full;
    assign w_accept  = ret_valid && ret_ready;

    // Pack the incoming event; non-pending entries are complete on arrival.
    always_comb begin
        w_in_entry           = '0;
        w_in_entry.insn      = ret_insn;
        w_in_entry.pc        = ret_pc;
        w_in_entry.next_pc   = ret_next_pc;
        w_in_entry.trap      = ret_trap;
        w_in_entry.rs1_addr  = ret_rs1_addr;
        w_in_entry.rs1_rdata = ret_rs1_rdata;
        w_in_entry.rs2_addr  = ret_rs2_addr;
        w_in_entry.rs2_rdata = ret_rs2_rdata;
        w_in_entry.rd        = ret_rd;
        w_in_entry.rd_wdata  = ret_wb_pend ? '0 : ret_rd_wdata;
        w_in_entry.mem_addr  = ret_mem_addr;
        w_in_entry.mem_rmask = ret_mem_rmask;
        w_in_entry.mem_wmask = ret_mem_wmask;
        w_in_entry.mem_wdata = ret_mem_wdata;
        w_in_entry.mem_rdata = '0;
        w_in_entry.pend      = ret_wb_pend;
        w_in_entry.done      = !ret_wb_pend;
    end

    // A complete event arriving at an empty buffer is the head itself, so it is
    // emitted straight away instead of taking a round trip through storage.
    assign w_bypass     = w_accept && w_fifo_empty && !ret_wb_pend;
    assign w_push       = w_accept && !w_bypass;
    assign w_emit_entry = w_bypass ? w_in_entry : w_head;
    assign w_emit       = w_emit_entry.done && (w_bypass || !w_fifo_empty);
    assign w_pop        = w_emit && !w_bypass;

    rvfi_trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk            (clk),
        .reset          (reset),
        .i_push         (w_push),
        .i_push_entry   (w_in_entry),
        .i_pop          (w_pop),
        .i_wb_valid     (wb_valid),
        .i_wb_rd_wdata  (wb_rd_wdata),
        .i_wb_mem_rdata (wb_mem_rdata),
        .o_full         (w_fifo_full),
        .o_empty        (w_fifo_empty),
        .o_head         (w_head)
    );

    // Emission register: one packet per cycle, fields hold when no packet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_order_cnt    <= '0;
            rvfi_valid     <= 1'b0;
            rvfi_order     <= '0;
            rvfi_insn      <= '0;
            rvfi_pre_pc    <= '0;
            rvfi_post_pc   <= '0;
            rvfi_trap      <= 1'b0;
            rvfi_rs1_addr  <= '0;
            rvfi_rs1_rdata <= '0;
            rvfi_rs2_addr  <= '0;
            rvfi_rs2_rdata <= '0;
            rvfi_rd        <= '0;
            rvfi_post_rd   <= '0;
            rvfi_mem_addr  <= '0;
            rvfi_mem_rmask <= '0;
            rvfi_mem_wmask <= '0;
            rvfi_mem_rdata <= '0;
            rvfi_mem_wdata <= '0;
        end else begin
            rvfi_valid <= w_emit;
            if (w_emit) begin
                r_order_cnt    <= r_order_cnt + 1'b1;
                rvfi_order     <= r_order_cnt;
                rvfi_insn      <= w_emit_entry.insn;
                rvfi_pre_pc    <= w_emit_entry.pc;
                rvfi_post_pc   <= w_emit_entry.next_pc;
                rvfi_trap      <= w_emit_entry.trap;
                rvfi_rs1_addr  <= w_emit_entry.rs1_addr;
                rvfi_rs1_rdata <= w_emit_entry.rs1_rdata;
                rvfi_rs2_addr  <= w_emit_entry.rs2_addr;
                rvfi_rs2_rdata <= w_emit_entry.rs2_rdata;
                rvfi_rd        <= w_emit_entry.rd;
                rvfi_post_rd   <= post_rd_value(w_emit_entry);
                rvfi_mem_addr  <= w_emit_entry.mem_addr;
                rvfi_mem_rmask <= w_emit_entry.mem_rmask;
                rvfi_mem_wmask <= w_emit_entry.mem_wmask;
                rvfi_mem_rdata <= w_emit_entry.pend ? w_emit_entry.mem_rdata : '0;
                rvfi_mem_wdata <= w_emit_entry.mem_wdata;
            end
        end
    end

`ifdef RVFI_TRACE_PC_CONT_EN
    logic            r_have_prev;
    logic            r_prev_trap;
    logic [XLEN-1:0] r_prev_next_pc;

    // Sticky flag: accepted pc must follow the previous accepted next_pc unless it trapped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_err         <= 1'b0;
            r_have_prev    <= 1'b0;
            r_prev_trap    <= 1'b0;
            r_prev_next_pc <= '0;
        end else if (w_accept) begin
            if (r_have_prev && !r_prev_trap && (ret_pc != r_prev_next_pc)) begin
                pc_err <= 1'b1;
            end
            r_have_prev    <= 1'b1;
            r_prev_trap    <= ret_trap;
            r_prev_next_pc <= ret_next_pc;
        end
    end
`endif

endmodule

// File: tb/tb_rvfi_trace_gen.sv
// Self-checking bench for rvfi_trace_gen: directed scenarios plus randomized
// traffic, checked against a queue-based model of the retire buffer rules.
module tb_rvfi_trace_gen;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ret_valid, ret_ready, ret_trap, ret_wb_pend;
    logic [31:0] ret_insn, ret_pc, ret_next_pc, ret_rs1_rdata, ret_rs2_rdata;
    logic [4:0]  ret_rs1_addr, ret_rs2_addr, ret_rd;
    logic [31:0] ret_rd_wdata, ret_mem_addr, ret_mem_wdata;
    logic [3:0]  ret_mem_rmask, ret_mem_wmask;
    logic        wb_valid;
    logic [31:0] wb_rd_wdata, wb_mem_rdata;
    logic        rvfi_valid, rvfi_trap;
    logic [7:0]  rvfi_order;
    logic [31:0] rvfi_insn, rvfi_pre_pc, rvfi_post_pc, rvfi_rs1_rdata, rvfi_rs2_rdata;
    logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd;
    logic [31:0] rvfi_post_rd, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
    logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;
`ifdef RVFI_TRACE_PC_CONT_EN
    logic        pc_err;
`endif

    always #5 clk = ~clk;

    rvfi_trace_gen #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .ret_valid(ret_valid), .ret_ready(ret_ready), .ret_insn(ret_insn),
        .ret_pc(ret_pc), .ret_next_pc(ret_next_pc), .ret_trap(ret_trap),
        .ret_rs1_addr(ret_rs1_addr), .ret_rs1_rdata(ret_rs1_rdata),
        .ret_rs2_addr(ret_rs2_addr), .ret_rs2_rdata(ret_rs2_rdata),
        .ret_rd(ret_rd), .ret_rd_wdata(ret_rd_wdata), .ret_wb_pend(ret_wb_pend),
        .ret_mem_addr(ret_mem_addr), .ret_mem_rmask(ret_mem_rmask),
        .ret_mem_wmask(ret_mem_wmask), .ret_mem_wdata(ret_mem_wdata),
        .wb_valid(wb_valid), .wb_rd_wdata(wb_rd_wdata), .wb_mem_rdata(wb_mem_rdata),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
        .rvfi_pre_pc(rvfi_pre_pc), .rvfi_post_pc(rvfi_post_pc), .rvfi_trap(rvfi_trap),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs1_rdata(rvfi_rs1_rdata),
        .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rs2_rdata(rvfi_rs2_rdata),
        .rvfi_rd(rvfi_rd), .rvfi_post_rd(rvfi_post_rd), .rvfi_mem_addr(rvfi_mem_addr),
        .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
        .rvfi_mem_rdata(rvfi_mem_rdata),
`ifdef RVFI_TRACE_PC_CONT_EN
        .pc_err(pc_err),
`endif
        .rvfi_mem_wdata(rvfi_mem_wdata)
    );

    typedef struct packed {
        logic        valid;
        logic [7:0]  order;
        logic [31:0] insn, pre_pc, post_pc;
        logic        trap;
        logic [4:0]  rs1_addr;
        logic [31:0] rs1_rdata;
        logic [4:0]  rs2_addr;
        logic [31:0] rs2_rdata;
        logic [4:0]  rd;
        logic [31:0] post_rd, mem_addr;
        logic [3:0]  mem_rmask, mem_wmask;
        logic [31:0] mem_rdata, mem_wdata;
    } pkt_t;

    typedef struct {
        logic [31:0] insn, pc, npc, rs1d, rs2d, rdval, maddr, wdata, mrdata;
        logic [4:0]  rs1a, rs2a, rd;
        logic [3:0]  rmask, wmask;
        logic        trap, pend, done;
    } ment_t;

    ment_t       mq[$];
    pkt_t        ex;
    int          m_order;
    bit          m_have_prev, m_prev_trap, m_pc_err;
    logic [31:0] m_prev_next;
    int          checks = 0;
    int          failures = 0;

    function automatic pkt_t dut_pkt();
        return {rvfi_valid, rvfi_order, rvfi_insn, rvfi_pre_pc, rvfi_post_pc, rvfi_trap,
                rvfi_rs1_addr, rvfi_rs1_rdata, rvfi_rs2_addr, rvfi_rs2_rdata, rvfi_rd,
                rvfi_post_rd, rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask,
                rvfi_mem_rdata, rvfi_mem_wdata};
    endfunction

    function automatic void model_reset();
        mq.delete();
        ex          = '0;
        m_order     = 0;
        m_have_prev = 0;
        m_prev_trap = 0;
        m_pc_err    = 0;
        m_prev_next = '0;
    endfunction

    // Applies one clock of the buffer rules to the model using the current inputs.
    function automatic void model_clock();
        ment_t inc, pkt;
        bit    acc, emit, stored;
        int    hit;
        acc = ret_valid && (mq.size() < DEPTH);
        inc.insn = ret_insn; inc.pc = ret_pc; inc.npc = ret_next_pc; inc.trap = ret_trap;
        inc.rs1a = ret_rs1_addr; inc.rs1d = ret_rs1_rdata;
        inc.rs2a = ret_rs2_addr; inc.rs2d = ret_rs2_rdata;
        inc.rd = ret_rd; inc.rdval = ret_rd_wdata; inc.maddr = ret_mem_addr;
        inc.rmask = ret_mem_rmask; inc.wmask = ret_mem_wmask; inc.wdata = ret_mem_wdata;
        inc.mrdata = '0; inc.pend = ret_wb_pend; inc.done = !ret_wb_pend;
        stored = acc;
        emit   = 0;
        pkt    = inc;
        if (mq.size() > 0 && mq[0].done) begin
            pkt  = mq.pop_front();
            emit = 1;
        end else if (mq.size() == 0 && acc && !ret_wb_pend) begin
            emit   = 1;
            stored = 0;
        end
        if (wb_valid) begin
            hit = -1;
            foreach (mq[i]) if (hit < 0 && !mq[i].done) hit = i;
            if (hit >= 0) begin
                mq[hit].rdval = wb_rd_wdata; mq[hit].mrdata = wb_mem_rdata; mq[hit].done = 1;
            end else if (stored && inc.pend) begin
                inc.rdval = wb_rd_wdata; inc.mrdata = wb_mem_rdata; inc.done = 1;
            end
        end
        if (stored) mq.push_back(inc);
        ex.valid = emit;
        if (emit) begin
            ex.order = 8'(m_order % 256);
            m_order++;
            ex.insn = pkt.insn; ex.pre_pc = pkt.pc; ex.post_pc = pkt.npc; ex.trap = pkt.trap;
            ex.rs1_addr = pkt.rs1a; ex.rs1_rdata = pkt.rs1d;
            ex.rs2_addr = pkt.rs2a; ex.rs2_rdata = pkt.rs2d; ex.rd = pkt.rd;
            ex.post_rd = (pkt.rd == 0 || pkt.trap) ? 32'h0 : pkt.rdval;
            ex.mem_addr = pkt.maddr; ex.mem_rmask = pkt.rmask; ex.mem_wmask = pkt.wmask;
            ex.mem_rdata = pkt.mrdata; ex.mem_wdata = pkt.wdata;
        end
        if (acc) begin
            if (m_have_prev && !m_prev_trap && ret_pc != m_prev_next) m_pc_err = 1;
            m_have_prev = 1; m_prev_trap = ret_trap; m_prev_next = ret_next_pc;
        end
    endfunction

    task automatic step();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ret_valid = 0;
        wb_valid  = 0;
    endtask

    task automatic set_ret(input logic [31:0] pc, input logic [31:0] npc, input logic [4:0] rd,
                           input logic [31:0] wdata, input logic pend, input logic trap);
        ret_valid = 1; ret_pc = pc; ret_next_pc = npc; ret_rd = rd; ret_rd_wdata = wdata;
        ret_wb_pend = pend; ret_trap = trap;
        ret_insn = $urandom; ret_rs1_addr = 5'($urandom); ret_rs1_rdata = $urandom;
        ret_rs2_addr = 5'($urandom); ret_rs2_rdata = $urandom; ret_mem_addr = $urandom;
        ret_mem_rmask = 4'($urandom); ret_mem_wmask = 4'($urandom); ret_mem_wdata = $urandom;
    endtask

    task automatic test_reset();
        idle();
        set_ret(32'h0, 32'h4, 5'd1, 32'h1, 1'b0, 1'b0);
        ret_valid = 0;
        wb_rd_wdata = '0; wb_mem_rdata = '0;
        reset = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dut_pkt() !== '0) begin
            failures++; $display("FAIL reset_outputs got=%h exp=0", dut_pkt());
        end
        reset = 0;
        #1;
        checks++;
        if (ret_ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready got=%b exp=1", ret_ready);
        end
    endtask

    task automatic test_alu_event();
        set_ret(32'h0, 32'h4, 5'd5, 32'h11, 1'b0, 1'b0);
        step();
        checks++;
        if ({rvfi_valid, rvfi_order, rvfi_post_rd, rvfi_post_pc} !== {1'b1, 8'd0, 32'h11, 32'h4}) begin
            failures++;
            $display("FAIL alu_first got=%b/%0d/%h/%h exp=1/0/11/4",
                     rvfi_valid, rvfi_order, rvfi_post_rd, rvfi_post_pc);
        end
        idle();
        step();
        checks++;
        if (dut_pkt() !== ex) begin
            failures++; $display("FAIL alu_hold got=%h exp=%h", dut_pkt(), ex);
        end
    endtask

    task automatic test_late_load();
        logic [7:0]  ord[2];
        logic [31:0] pcs[2], prd[2];
        int          n = 0;
        set_ret(32'h4, 32'h8, 5'd7, $urandom, 1'b1, 1'b0);
        step();
        set_ret(32'h8, 32'hC, 5'd3, 32'h22, 1'b0, 1'b0);
        step();
        idle();
        step();
        wb_valid = 1; wb_rd_wdata = 32'hAB; wb_mem_rdata = $urandom;
        for (int c = 0; c < 7; c++) begin
            step();
            wb_valid = 0;
            checks++;
            if (dut_pkt() !== ex) begin
                failures++; $display("FAIL late_load_pkt c=%0d got=%h exp=%h", c, dut_pkt(), ex);
            end
            if (rvfi_valid === 1'b1 && n < 2) begin
                ord[n] = rvfi_order; pcs[n] = rvfi_pre_pc; prd[n] = rvfi_post_rd; n++;
            end
        end
        checks++;
        if (n != 2 || {ord[0], pcs[0], prd[0], ord[1], pcs[1], prd[1]} !==
                      {8'd1, 32'h4, 32'hAB, 8'd2, 32'h8, 32'h22}) begin
            failures++;
            $display("FAIL late_load_seq n=%0d got=%0d/%h/%h,%0d/%h/%h exp=1/4/ab,2/8/22",
                     n, ord[0], pcs[0], prd[0], ord[1], pcs[1], prd[1]);
        end
    endtask

    task automatic test_full();
        for (int k = 0; k < DEPTH; k++) begin
            checks++;
            if (ret_ready !== 1'b1) begin
                failures++; $display("FAIL fill_ready k=%0d got=%b exp=1", k, ret_ready);
            end
            set_ret(32'h100 + 32'(4 * k), 32'h104 + 32'(4 * k), 5'(k + 1), $urandom, 1'b1, 1'b0);
            step();
        end
        set_ret(32'h200, 32'h204, 5'd9, 32'h99, 1'b0, 1'b0);
        checks++;
        if (ret_ready !== 1'b0) begin
            failures++; $display("FAIL full_ready got=%b exp=0", ret_ready);
        end
        step();
        idle();
        wb_valid = 1; wb_rd_wdata = $urandom; wb_mem_rdata = $urandom;
        step();
        wb_valid = 0;
        checks++;
        if (ret_ready !== 1'b0) begin
            failures++; $display("FAIL full_after_wb got=%b exp=0", ret_ready);
        end
        step();
        checks++;
        if (ret_ready !== 1'b1 || dut_pkt() !== ex) begin
            failures++; $display("FAIL full_pop ready=%b got=%h exp=%h", ret_ready, dut_pkt(), ex);
        end
        for (int c = 0; c < 8; c++) begin
            wb_valid = (c < 3); wb_rd_wdata = $urandom; wb_mem_rdata = $urandom;
            step();
            checks++;
            if (dut_pkt() !== ex) begin
                failures++; $display("FAIL full_drain c=%0d got=%h exp=%h", c, dut_pkt(), ex);
            end
        end
        idle();
    endtask

    task automatic test_order_wrap();
        int prev = -1;
        int wraps = 0;
        for (int c = 0; c < 260; c++) begin
            set_ret(32'(c * 4), 32'(c * 4 + 4), 5'($urandom), $urandom, 1'b0, 1'b0);
            step();
            checks++;
            if (dut_pkt() !== ex) begin
                failures++; $display("FAIL wrap_pkt c=%0d got=%h exp=%h", c, dut_pkt(), ex);
            end
            if (rvfi_valid === 1'b1) begin
                if (prev == 255 && rvfi_order == 8'd0) wraps++;
                prev = int'(rvfi_order);
            end
        end
        idle();
        step();
        checks++;
        if (wraps != 1) begin
            failures++; $display("FAIL order_wrap got=%0d exp=1", wraps);
        end
    endtask

    task automatic test_rd0_and_stray_wb();
        set_ret(32'h300, 32'h304, 5'd0, 32'hFFFF, 1'b0, 1'b0);
        step();
        checks++;
        if (rvfi_valid !== 1'b1 || rvfi_post_rd !== 32'h0) begin
            failures++; $display("FAIL rd0_post_rd got=%b/%h exp=1/0", rvfi_valid, rvfi_post_rd);
        end
        idle();
        step();
        wb_valid = 1; wb_rd_wdata = 32'h5555; wb_mem_rdata = 32'h6666;
        step();
        wb_valid = 0;
        checks++;
        if (dut_pkt() !== ex || rvfi_valid !== 1'b0) begin
            failures++; $display("FAIL stray_wb got=%h exp=%h", dut_pkt(), ex);
        end
        set_ret(32'h304, 32'h308, 5'd4, $urandom, 1'b1, 1'b0);
        step();
        idle();
        for (int c = 0; c < 6; c++) begin
            wb_valid = (c == 2); wb_rd_wdata = $urandom; wb_mem_rdata = $urandom;
            step();
            checks++;
            if (dut_pkt() !== ex) begin
                failures++; $display("FAIL pend_after_stray c=%0d got=%h exp=%h", c, dut_pkt(), ex);
            end
        end
        set_ret(32'h308, 32'h30C, 5'd6, $urandom, 1'b1, 1'b0);
        wb_valid = 1; wb_rd_wdata = 32'hC0DE; wb_mem_rdata = 32'hBEEF;
        for (int c = 0; c < 3; c++) begin
            step();
            idle();
            checks++;
            if (dut_pkt() !== ex) begin
                failures++; $display("FAIL same_cycle_wb c=%0d got=%h exp=%h", c, dut_pkt(), ex);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] pc = 32'h1000;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 99) < 60)
                set_ret(pc, pc + 4, 5'($urandom), $urandom, ($urandom_range(0, 99) < 35),
                        ($urandom_range(0, 99) < 10));
            else
                ret_valid = 0;
            wb_valid = ($urandom_range(0, 99) < 30);
            wb_rd_wdata = $urandom; wb_mem_rdata = $urandom;
            checks++;
            if (ret_ready !== (mq.size() < DEPTH)) begin
                failures++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, ret_ready, mq.size() < DEPTH);
            end
            if (ret_valid && ret_ready) pc = pc + 4;
            step();
            checks++;
            if (dut_pkt() !== ex) begin
                failures++; $display("FAIL rand_pkt c=%0d got=%h exp=%h", c, dut_pkt(), ex);
            end
        end
        idle();
        for (int c = 0; c < 12; c++) begin
            wb_valid = 1; wb_rd_wdata = $urandom; wb_mem_rdata = $urandom;
            step();
            checks++;
            if (dut_pkt() !== ex) begin
                failures++; $display("FAIL rand_drain c=%0d got=%h exp=%h", c, dut_pkt(), ex);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        set_ret(32'h400, 32'h404, 5'd2, $urandom, 1'b1, 1'b0);
        step();
        set_ret(32'h404, 32'h408, 5'd3, $urandom, 1'b0, 1'b0);
        step();
        idle();
        reset = 1;
        model_reset();
        #1;
        checks++;
        if (dut_pkt() !== '0 || ret_ready !== 1'b1) begin
            failures++; $display("FAIL mid_reset got=%h ready=%b exp=0/1", dut_pkt(), ret_ready);
        end
        @(posedge clk);
        #1;
        reset = 0;
        wb_valid = 1; wb_rd_wdata = $urandom; wb_mem_rdata = $urandom;
        step();
        wb_valid = 0;
        checks++;
        if (rvfi_valid !== 1'b0) begin
            failures++; $display("FAIL mid_reset_discard got=%b exp=0", rvfi_valid);
        end
        set_ret(32'h0, 32'h4, 5'd8, 32'h77, 1'b0, 1'b0);
        step();
        idle();
        checks++;
        if (dut_pkt() !== ex || rvfi_order !== 8'd0 || rvfi_valid !== 1'b1) begin
            failures++; $display("FAIL mid_reset_restart got=%h exp=%h", dut_pkt(), ex);
        end
    endtask

`ifdef RVFI_TRACE_PC_CONT_EN
    task automatic test_pc_cont();
        logic [31:0] pcs[6] = '{32'h0, 32'h4, 32'h10, 32'h14, 32'h18, 32'h1C};
        logic        exp_err[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        reset = 1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 0;
        for (int k = 0; k < 6; k++) begin
            set_ret(pcs[k], pcs[k] + 4, 5'd1, $urandom, 1'b0, 1'b0);
            step();
            checks++;
            if (pc_err !== exp_err[k] || pc_err !== m_pc_err) begin
                failures++; $display("FAIL pc_err k=%0d got=%b exp=%b", k, pc_err, exp_err[k]);
            end
        end
        idle();
        reset = 1;
        #1;
        checks++;
        if (pc_err !== 1'b0) begin
            failures++; $display("FAIL pc_err_reset got=%b exp=0", pc_err);
        end
        model_reset();
        @(posedge clk);
        #1;
        reset = 0;
        set_ret(32'h40, 32'h44, 5'd1, $urandom, 1'b0, 1'b1);
        step();
        set_ret(32'h80, 32'h84, 5'd1, $urandom, 1'b0, 1'b0);
        step();
        idle();
        checks++;
        if (pc_err !== 1'b0) begin
            failures++; $display("FAIL pc_err_after_trap got=%b exp=0", pc_err);
        end
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu_event();
        test_late_load();
        test_full();
        test_order_wrap();
        test_rd0_and_stray_wb();
        test_random();
        test_reset_mid();
`ifdef RVFI_TRACE_PC_CONT_EN
        test_pc_cont();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
